shift_pass_scheduler: RTL

- Shares one combinational pass-limited shifter (at most MAX_STEP bit positions per pass) between two requesters.
- Round-robin arbitrates requests and sequences multi-pass shifts of arbitrary amount by feeding the shifter's result back as the next pass's input.
- Returns the result through a valid/ready response port.
- Sits between the LEG ALU-op decode and the shared shifter datapath.

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_pass_scheduler_rr_arb2.sv | 12 +
 rtl/shift_pass_scheduler.sv | 82 ++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared types, defaults and effective-amount helper for the shift pass scheduler
package shift_pkg;
  typedef enum logic [1:0] {OP_LSR, OP_LSL, OP_ASR, OP_ROR} op_e;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int WIDTH_DEF = 8;
  localparam int MAX_STEP_DEF = 4;
  // Amount actually worth shifting: saturates logical/arith shifts, wraps rotates
  function automatic logic [31:0] eff_amount(input logic [1:0] op, input logic [31:0] amount,
                                             input logic [31:0] width);
    logic [31:0] lim;
    lim = (op == OP_ASR) ? width - 32'd1 : width;
    return (op == OP_ROR) ? amount % width : ((amount < lim) ? amount : lim);
  endfunction
endpackage

// File: rtl/shift_pass_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter favouring the requester that did not win last
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_id
);
  always_comb begin
    grant_id = valid[1] & (~valid[0] | ~last_grant);
    grant = {valid[1] & grant_id, valid[0] & ~grant_id};
  end
endmodule

// File: rtl/shift_pass_scheduler.sv
// shift_pass_scheduler: arbitrates two requesters onto a pass-limited shifter and loops passes to completion
module shift_pass_scheduler
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int MAX_STEP = MAX_STEP_DEF,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_value,
  input  logic [AMT_W-1:0] req0_amount,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_value,
  input  logic [AMT_W-1:0] req1_amount,
  input  logic [1:0]       req1_op,
  output logic [WIDTH-1:0] sh_value,
  output logic [7:0]       sh_amount,
  output logic [1:0]       sh_op,
  input  logic [WIDTH-1:0] sh_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_id
);
  state_e state, state_nx;
  logic [WIDTH-1:0] acc, sel_value;
  logic [AMT_W-1:0] rem, step, sel_amount, eff;
  logic [1:0] op_r, sel_op, grant;
  logic id_r, last_grant, grant_id, accept;
  rr_arb2 u_arb (
    .valid({req1_valid, req0_valid}),
    .last_grant(last_grant),
    .grant(grant),
    .grant_id(grant_id)
  );
  always_comb begin
    step = (rem < AMT_W'(MAX_STEP)) ? rem : AMT_W'(MAX_STEP);
    req0_ready = (state == IDLE) && grant[0] && !rst;
    req1_ready = (state == IDLE) && grant[1] && !rst;
    accept = req0_ready | req1_ready;
    sel_value = grant_id ? req1_value : req0_value;
    sel_amount = grant_id ? req1_amount : req0_amount;
    sel_op = grant_id ? req1_op : req0_op;
    eff = AMT_W'(eff_amount(sel_op, 32'(sel_amount), 32'(WIDTH)));
    sh_value = acc;
    sh_op = op_r;
    sh_amount = (state == SHIFT) ? 8'(step) : 8'd0;
    rsp_valid = (state == DONE);
    rsp_result = rsp_valid ? acc : '0;
    rsp_id = rsp_valid & id_r;
    state_nx = (state == IDLE)  ? (accept ? ((eff == '0) ? DONE : SHIFT) : IDLE) :
               (state == SHIFT) ? ((rem == step) ? DONE : SHIFT) :
               (rsp_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      rem <= '0;
      op_r <= '0;
      id_r <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      if (accept) begin
        acc <= sel_value;
        op_r <= sel_op;
        id_r <= grant_id;
        last_grant <= grant_id;
        rem <= eff;
      end else if (state == SHIFT) begin
        acc <= sh_result;
        rem <= rem - step;
      end
    end
  end
endmodule
